// File: rtl/ase_hssi_loopback_emul_if.sv
// AXI-S TX/RX stream pair between an HSSI AFU (master) and the loopback emulator (slave).
interface ase_hssi_loopback_emul_if #(
  parameter int DATA_WIDTH = 64
);
  logic                    tx_tvalid;
  logic                    tx_tready;
  logic [DATA_WIDTH-1:0]   tx_tdata;
  logic [DATA_WIDTH/8-1:0] tx_tkeep;
  logic                    tx_tlast;
  logic                    tx_tuser;
  logic                    tx_pause;
  logic                    rx_tvalid;
  logic [DATA_WIDTH-1:0]   rx_tdata;
  logic [DATA_WIDTH/8-1:0] rx_tkeep;
  logic                    rx_tlast;
  logic                    rx_tuser;

  modport master (
    output tx_tvalid, tx_tdata, tx_tkeep, tx_tlast, tx_tuser, tx_pause,
    input  tx_tready, rx_tvalid, rx_tdata, rx_tkeep, rx_tlast, rx_tuser
  );

  modport slave (
    input  tx_tvalid, tx_tdata, tx_tkeep, tx_tlast, tx_tuser, tx_pause,
    output tx_tready, rx_tvalid, rx_tdata, rx_tkeep, rx_tlast, rx_tuser
  );
endinterface

// File: rtl/ase_hssi_loopback_emul.sv
// Store-and-forward loopback link partner: replays each complete TX frame on RX.
// Optional ASE_HSSI_LB_ERR_INJECT_EN forces rx_tuser on every ERR_PERIOD-th forwarded frame.
module ase_hssi_loopback_emul #(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 64,
  parameter int ERR_PERIOD = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ase_hssi_loopback_emul_if.slave hssi,
  output logic [31:0]             frame_cnt,
  output logic [15:0]             drop_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int KW = DATA_WIDTH / 8;
  localparam int EW = DATA_WIDTH + KW + 2;
  localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  if ((DATA_WIDTH % 8) != 0 || FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      ERR_PERIOD < 1) begin : gBadParams
    $error("ase_hssi_loopback_emul: illegal parameter set");
  end

  // Read FSM: IDLE = rx outputs empty | SEND = rx outputs hold a beat of the current frame
  typedef enum logic {IDLE, SEND} rdState_e;
  rdState_e state, nextState;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr, wrCommit, rdPtr, occupancy, fcQ;
  logic [EW-1:0] rdEntry;
  logic          runQ, dropMode, overflow, txFire, wrEn, commit;
  logic          rdEn, rdLast, frameDone, inject;

  assign occupancy      = wrPtr - rdPtr;
  assign overflow       = (occupancy == DEPTH_P) && (wrPtr != wrCommit);
  assign hssi.tx_tready = runQ && ((occupancy != DEPTH_P) || dropMode || overflow);
  assign txFire         = hssi.tx_tvalid && hssi.tx_tready;
  assign wrEn           = txFire && !dropMode && !overflow;
  assign commit         = wrEn && hssi.tx_tlast;
  assign rdEntry        = mem[rdPtr[AW-1:0]];
  assign rdLast         = rdEntry[1];
  assign frameDone      = rdEn && rdLast;

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr[AW-1:0]] <= {hssi.tx_tdata, hssi.tx_tkeep, hssi.tx_tlast, hssi.tx_tuser};
  end

  // An oversize frame is rewound to the last commit point and the rest of it is swallowed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      runQ     <= 1'b0;
      wrPtr    <= '0;
      wrCommit <= '0;
      dropMode <= 1'b0;
      drop_cnt <= '0;
    end else begin
      runQ <= 1'b1;
      if (wrEn) begin
        wrPtr <= wrPtr + PTR_ONE;
        if (hssi.tx_tlast) wrCommit <= wrPtr + PTR_ONE;
      end else if (txFire && overflow) begin
        wrPtr <= wrCommit;
      end
      if (txFire && (dropMode || overflow)) begin
        if (hssi.tx_tlast) begin
          dropMode <= 1'b0;
          if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end else begin
          dropMode <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (fcQ != '0 && !hssi.tx_pause) nextState = SEND;
      SEND: if (hssi.rx_tlast) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    rdEn = 1'b0;
    case (state)
      IDLE: rdEn = (fcQ != '0) && !hssi.tx_pause;
      SEND: rdEn = !hssi.rx_tlast;
      default: rdEn = 1'b0;
    endcase
  end

`ifdef ASE_HSSI_LB_ERR_INJECT_EN
  localparam int EPW = $clog2(ERR_PERIOD + 1);
  localparam logic [EPW-1:0] ERR_LAST = EPW'(ERR_PERIOD - 1);
  logic [EPW-1:0] errCnt;

  assign inject = frameDone && (errCnt == ERR_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n)         errCnt <= '0;
    else if (frameDone) errCnt <= inject ? '0 : errCnt + EPW'(1);
  end
`else
  assign inject = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdPtr          <= '0;
      fcQ            <= '0;
      frame_cnt      <= '0;
      hssi.rx_tvalid <= 1'b0;
      hssi.rx_tdata  <= '0;
      hssi.rx_tkeep  <= '0;
      hssi.rx_tlast  <= 1'b0;
      hssi.rx_tuser  <= 1'b0;
    end else begin
      if (rdEn) rdPtr <= rdPtr + PTR_ONE;
      case ({commit, frameDone})
        2'b10:   fcQ <= fcQ + PTR_ONE;
        2'b01:   fcQ <= fcQ - PTR_ONE;
        default: ;
      endcase
      if (frameDone) frame_cnt <= frame_cnt + 32'd1;
      hssi.rx_tvalid <= rdEn;
      if (rdEn) begin
        hssi.rx_tdata <= rdEntry[EW-1 -: DATA_WIDTH];
        hssi.rx_tkeep <= rdEntry[KW+1 -: KW];
        hssi.rx_tlast <= rdEntry[1];
        hssi.rx_tuser <= rdEntry[0] | inject;
      end else begin
        hssi.rx_tdata <= '0;
        hssi.rx_tkeep <= '0;
        hssi.rx_tlast <= 1'b0;
        hssi.rx_tuser <= 1'b0;
      end
    end
  end
endmodule

// File: doc/ase_hssi_loopback_emul.md
# ase_hssi_loopback_emul

Store-and-forward Ethernet link-partner emulator for ASE simulation. It sits on the MAC side of one HSSI channel. It accepts frames the AFU transmits on the AXI-S TX stream and replays each complete frame on the RX stream, so HSSI AFUs can be exercised without a MAC model. One instance per channel, clocked by that channel's HSSI PLL clock.

## Interface
Parameters:
- DATA_WIDTH, 64: tdata width in bits; multiple of 8.
- FIFO_DEPTH, 64: beat storage; power of 2, ≥4.
- ERR_PERIOD, 16: error-injection period in frames; ≥1; used only with the macro.

Ports:
- clk  in  1  channel clock; sole clock.
- rst_n  in  1  reset; synchronous, active-low.
- tx_tvalid  in  1  AFU TX beat valid.
- tx_tready  out  1  block accepts TX beat.
- tx_tdata  in  DATA_WIDTH  TX data.
- tx_tkeep  in  DATA_WIDTH/8  TX byte enables.
- tx_tlast  in  1  last beat of frame.
- tx_tuser  in  1  client error flag.
- tx_pause  in  1  AFU pause request; holds off new RX frames.
- rx_tvalid  out  1  RX beat valid; no backpressure.
- rx_tdata  out  DATA_WIDTH  RX data.
- rx_tkeep  out  DATA_WIDTH/8  RX byte enables.
- rx_tlast  out  1  RX last beat.
- rx_tuser  out  1  RX error flag.
- frame_cnt  out  32  frames forwarded; wraps.
- drop_cnt  out  16  oversize frames dropped; saturates at 0xFFFF.

## Operation
- FIFO entry = {tdata, tkeep, tlast, tuser}. Pointers are log2(FIFO_DEPTH)+1 bits: speculative wr_ptr, committed wr_commit, rd_ptr.
- Write: on a TX handshake, store the beat at wr_ptr and increment wr_ptr. On tlast, wr_commit ← wr_ptr+1 and committed-frame counter fc_q += 1.
- tx_tready = (wr_ptr − rd_ptr < FIFO_DEPTH) OR drop mode.
- Oversize: if wr_ptr − rd_ptr == FIFO_DEPTH, the current frame is not yet committed, and tx_tvalid is high:
  - enter DROP and rewind wr_ptr ← wr_commit;
  - in DROP, accept and discard beats; leave DROP on the tlast handshake; drop_cnt += 1.
  - Committed frames are unaffected.
- Read FSM, IDLE/SEND:
  - IDLE→SEND when fc_q > 0 and tx_pause == 0.
  - In SEND, read one beat per cycle from rd_ptr into the registered outputs.
  - SEND→IDLE after emitting the tlast beat; fc_q −= 1 and frame_cnt += 1 on that beat.
  - tx_pause is sampled only in IDLE. It never interrupts a frame in flight.
- Same-cycle commit (+1) and frame completion (−1) on fc_q net to zero.
- Reset: all pointers, fc_q, FSM, DROP state and counters clear. Any partial or stored frames are discarded.

## Timing
- Reset values: tx_tready 0, and all rx_* outputs, frame_cnt and drop_cnt 0. tx_tready rises the first cycle after rst_n goes high.
- Latency: tlast handshake at cycle N; commit is visible at N+1; first RX beat is at N+2 if the FSM was IDLE and unpaused.
- RX beats of one frame are contiguous; rx_tvalid has no gaps within a frame.
- Back-to-back frames: rx_tvalid is low for at least one cycle between frames (SEND→IDLE→SEND).
- Full boundary: tready drops in the same cycle the occupancy reaches FIFO_DEPTH.
- Wrap-around relies on the extra pointer bit.

## Configuration
- ASE_HSSI_LB_ERR_INJECT_EN defined: rx_tuser is forced to 1 on the tlast beat of forwarded frames ERR_PERIOD, 2·ERR_PERIOD, … (counted from reset). It is ORed with the stored tuser.
- Macro undefined: rx_tuser equals the stored tx_tuser, and ERR_PERIOD is ignored.

## Test plan
- Single 3-beat frame, tkeep of last beat 0x0F → RX shows identical 3 beats starting 2 cycles after tlast; frame_cnt=1.
- 20 back-to-back 4-beat frames with FIFO_DEPTH=64 → all 20 replayed in order, ≥1 idle cycle between frames, tready never drops; frame_cnt=20.
- One 70-beat frame, then one 2-beat frame → drop_cnt=1, tready stays 1 throughout; only the 2-beat frame appears on RX.
- tx_pause held high while 2 frames are committed → no rx_tvalid; on release, the first frame starts 1 cycle later. Pause raised mid-frame → that frame completes.
- rst_n low for 1 cycle mid-RX-frame with 3 frames stored → outputs 0 and FIFO empty; the next frame replays normally.
- With ASE_HSSI_LB_ERR_INJECT_EN and ERR_PERIOD=4, 8 frames → rx_tuser=1 only on the tlast beats of frames 4 and 8. Without the macro → rx_tuser is always 0.
